// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sequencer sharing one multi-cycle FP8 adder among NREQ requesters.
// Define FPA_ARB_TIMEOUT_EN to add a WAIT-state timeout with adder abort and error response.
module fp_add_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_op1,
    input  logic [8*NREQ-1:0] req_op2,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_res,
    output logic              rsp_err,
    output logic              add_start,
    output logic [7:0]        add_op1,
    output logic [7:0]        add_op2,
    input  logic              add_done,
    input  logic [7:0]        add_res,
    output logic              add_abort
);
    localparam int PW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_params
        $error("fp_add_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
    end

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, gnt_q, gnt_d, sel, idx;
    logic            found, done_ok;
    logic [NREQ-1:0] req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_res_q, rsp_res_d, add_op1_q, add_op1_d, add_op2_q, add_op2_d;
    logic            add_start_q, add_start_d;
    logic [7:0]      op1_a [NREQ];
    logic [7:0]      op2_a [NREQ];

`ifdef FPA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_err_q, rsp_err_d, add_abort_q, add_abort_d;
    assign rsp_err   = rsp_err_q;
    assign add_abort = add_abort_q;
`else
    assign rsp_err   = 1'b0;
    assign add_abort = 1'b0;
`endif

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign op1_a[i] = req_op1[8*i +: 8];
        assign op2_a[i] = req_op2[8*i +: 8];
    end

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(NREQ - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] p);
        return {{(NREQ-1){1'b0}}, 1'b1} << p;
    endfunction

    // Search starts just after the last-served requester and wraps modulo NREQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = nxt(ptr_q);
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
            idx = nxt(idx);
        end
    end

    // A done coinciding with our own start pulse cannot belong to this operation.
    assign done_ok = add_done && !add_start_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        req_ready_d = '0;
        add_start_d = 1'b0;
        rsp_valid_d = '0;
        rsp_res_d   = rsp_res_q;
        add_op1_d   = add_op1_q;
        add_op2_d   = add_op2_q;
`ifdef FPA_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
        add_abort_d = 1'b0;
`endif
        case (state_q)
            IDLE: if (found) begin
                gnt_d       = sel;
                add_op1_d   = op1_a[sel];
                add_op2_d   = op2_a[sel];
                req_ready_d = onehot(sel);
                add_start_d = 1'b1;
                state_d     = WAIT;
`ifdef FPA_ARB_TIMEOUT_EN
                cnt_d       = '0;
`endif
            end
            WAIT: if (done_ok) begin
                rsp_res_d   = add_res;
                rsp_valid_d = onehot(gnt_q);
                state_d     = RESP;
`ifdef FPA_ARB_TIMEOUT_EN
                rsp_err_d   = 1'b0;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                rsp_res_d   = 8'h00;
                rsp_err_d   = 1'b1;
                add_abort_d = 1'b1;
                rsp_valid_d = onehot(gnt_q);
                state_d     = RESP;
            end else begin
                cnt_d       = cnt_q + CW'(1);
`endif
            end
            RESP: begin
                ptr_d   = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= PW'(NREQ - 1);
            gnt_q       <= '0;
            req_ready_q <= '0;
            add_start_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_res_q   <= 8'h00;
            add_op1_q   <= 8'h00;
            add_op2_q   <= 8'h00;
`ifdef FPA_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
            add_abort_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            req_ready_q <= req_ready_d;
            add_start_q <= add_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            add_op1_q   <= add_op1_d;
            add_op2_q   <= add_op2_d;
`ifdef FPA_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
            add_abort_q <= add_abort_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign add_start = add_start_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign add_op1   = add_op1_q;
    assign add_op2   = add_op2_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed and randomized checks of fp_add_arbiter against a
// timestamp-based transaction model of the arbiter/adder handshake.
module tb_fp_add_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_op1   = '0;
    logic [8*NREQ-1:0] req_op2   = '0;
    logic              add_done  = 1'b0;
    logic [7:0]        add_res   = '0;
    logic [NREQ-1:0]   req_ready, rsp_valid;
    logic [7:0]        rsp_res, add_op1, add_op2;
    logic              rsp_err, add_start, add_abort;

    fp_add_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_err(rsp_err),
        .add_start(add_start), .add_op1(add_op1), .add_op2(add_op2), .add_done(add_done),
        .add_res(add_res), .add_abort(add_abort)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int gq[$];

    // Model: a transaction is issued at edge t_issue, answered at t_resp, arbiter free after t_resp+1.
    bit              busy, responded;
    int              last, g, t_issue, t_resp, edge_n;
    logic [NREQ-1:0] e_ready, e_valid;
    logic            e_start, e_err, e_abort;
    logic [7:0]      e_res, e_op1, e_op2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr(input int lst, input logic [NREQ-1:0] v);
        for (int i = 1; i <= NREQ; i++)
            if (v[(lst + i) % NREQ]) return (lst + i) % NREQ;
        return -1;
    endfunction

    task automatic model_reset();
        busy = 0; responded = 0; last = NREQ - 1; g = 0; t_issue = 0; t_resp = 0; edge_n = 0;
        e_ready = '0; e_valid = '0; e_start = 0; e_err = 0; e_abort = 0;
        e_res = 8'h00; e_op1 = 8'h00; e_op2 = 8'h00;
    endtask

    task automatic respond(input logic [7:0] r, input logic er);
        e_valid = NREQ'(1) << g; e_res = r; e_err = er; responded = 1; t_resp = edge_n;
    endtask

    task automatic model_edge();
        e_ready = '0; e_valid = '0; e_start = 0; e_abort = 0;
        if (!busy) begin
            if (req_valid != '0) begin
                g = rr(last, req_valid);
                e_ready = NREQ'(1) << g; e_start = 1;
                e_op1 = req_op1[8*g +: 8]; e_op2 = req_op2[8*g +: 8];
                busy = 1; responded = 0; t_issue = edge_n;
            end
        end else if (!responded) begin
            if (edge_n >= t_issue + 2 && add_done) respond(add_res, 1'b0);
`ifdef FPA_ARB_TIMEOUT_EN
            else if (edge_n == t_issue + TIMEOUT) begin
                respond(8'h00, 1'b1);
                e_abort = 1;
            end
`endif
        end else if (edge_n == t_resp + 1) begin
            busy = 0; last = g;
        end
        edge_n++;
    endtask

    task automatic compare();
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("add_start", 32'(add_start), 32'(e_start));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
        chk("add_abort", 32'(add_abort), 32'(e_abort));
        if (e_valid != '0) begin
            chk("rsp_res", 32'(rsp_res), 32'(e_res));
            chk("rsp_err", 32'(rsp_err), 32'(e_err));
        end
        if (busy && !responded) begin
            chk("add_op1", 32'(add_op1), 32'(e_op1));
            chk("add_op2", 32'(add_op2), 32'(e_op2));
        end
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gq.push_back(i);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_req_ready"}, 32'(req_ready), 32'(0));
        chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
        chk({nm, "_rsp_res"}, 32'(rsp_res), 32'(0));
        chk({nm, "_rsp_err"}, 32'(rsp_err), 32'(0));
        chk({nm, "_add_start"}, 32'(add_start), 32'(0));
        chk({nm, "_add_op1"}, 32'(add_op1), 32'(0));
        chk({nm, "_add_op2"}, 32'(add_op2), 32'(0));
        chk({nm, "_add_abort"}, 32'(add_abort), 32'(0));
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while (req_valid != '0 || busy) begin
            add_done = 1'b1;
            add_res  = 8'($urandom);
            cycle();
            req_valid &= ~e_ready;
            if (++k > bound) begin
                n_chk++; n_fail++;
                $display("FAIL drain_timeout: still busy after %0d cycles", bound);
                break;
            end
        end
        add_done = 1'b0;
    endtask

    initial begin
        int exp_f[6] = '{0, 1, 2, 3, 0, 1};
        model_reset();
        req_valid = '1;
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk_zero("reset");
        end
        for (int i = 0; i < NREQ; i++) begin
            req_op1[8*i +: 8] = 8'(16 + i);
            req_op2[8*i +: 8] = 8'(32 + i);
        end
        rst_n    = 1'b1;
        add_done = 1'b1;
        for (int k = 0; k < 60 && gq.size() < 6; k++) cycle();
        chk("fair_count", 32'(gq.size()), 32'(6));
        if (gq.size() == 6)
            for (int i = 0; i < 6; i++) chk("fair_order", 32'(gq[i]), 32'(exp_f[i]));
        req_valid = '0;
        drain(20);

        gq.delete();
        req_valid = 4'b1001;
        drain(30);
        chk("wrap_count", 32'(gq.size()), 32'(2));
        if (gq.size() == 2) begin
            chk("wrap_first", 32'(gq[0]), 32'(3));
            chk("wrap_second", 32'(gq[1]), 32'(0));
        end

        req_valid = 4'b0100;
        req_op1[23:16] = 8'h12;
        req_op2[23:16] = 8'h13;
        add_done = 1'b0;
        cycle();
        chk("single_ready", 32'(req_ready), 32'(4'b0100));
        chk("single_start", 32'(add_start), 32'(1));
        chk("single_op1", 32'(add_op1), 32'(8'h12));
        chk("single_op2", 32'(add_op2), 32'(8'h13));
        req_valid = '0;
        cycle();
        cycle();
        add_done = 1'b1;
        add_res  = 8'h25;
        cycle();
        chk("single_rsp_valid", 32'(rsp_valid), 32'(4'b0100));
        chk("single_rsp_res", 32'(rsp_res), 32'(8'h25));
        add_done = 1'b0;
        cycle();
        chk("single_rsp_clear", 32'(rsp_valid), 32'(0));
        drain(10);

        req_valid = 4'b1000;
        cycle();
        req_valid = '0;
        cycle();
        cycle();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk_zero("mid_reset");
        req_valid = '1;
        rst_n = 1'b1;
        cycle();
        chk("after_reset_grant", 32'(req_ready), 32'(4'b0001));
        req_valid &= ~e_ready;
        drain(30);

`ifdef FPA_ARB_TIMEOUT_EN
        req_valid = 4'b0001;
        add_done  = 1'b0;
        cycle();
        req_valid = '0;
        for (int j = 1; j <= TIMEOUT; j++) begin
            cycle();
            if (j < TIMEOUT) chk("to_no_abort", 32'(add_abort), 32'(0));
        end
        chk("to_abort", 32'(add_abort), 32'(1));
        chk("to_rsp_valid", 32'(rsp_valid), 32'(4'b0001));
        chk("to_rsp_err", 32'(rsp_err), 32'(1));
        chk("to_rsp_res", 32'(rsp_res), 32'(0));
        add_done = 1'b1;
        cycle();
        chk("to_late_done", 32'(rsp_valid), 32'(0));
        chk("to_abort_once", 32'(add_abort), 32'(0));
        add_done = 1'b0;
        drain(10);
`endif

        for (int c = 0; c < 3000; c++) begin
            add_done = ($urandom_range(0, 2) == 0);
            add_res  = 8'($urandom);
            cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (e_ready[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) == 0);
                    req_op1[8*i +: 8] = 8'($urandom);
                    req_op2[8*i +: 8] = 8'($urandom);
                end
            end
        end
        req_valid = '0;
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
